synapse_event_stage: RTL and testbench

- Synapse stage directly upstream of the soma in a physical neuron.
- Accepts pre-synaptic spike events (pre-synaptic id plus timestamp) into a small FIFO and looks up each event's 16-bit synaptic weight in a locally programmed weight table.
- Computes the inter-spike interval since the last delivered event.
- Presents {weight, interval} to the soma as a single-cycle valid pulse; events arriving while the soma is busy (refractory) are discarded and counted.

---
 rtl/neuron_pkg.sv | 15 +
 rtl/synapse_event_stage_if.sv | 29 ++
 rtl/sync_event_fifo.sv | 52 +++++
 rtl/synapse_event_stage.sv | 175 +++++++++++++++++
 tb/tb_synapse_event_stage.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/neuron_pkg.sv
// Shared types and constants for the synapse/soma event path.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        ISSUE  = 2'd2
    } state_t;

    localparam int W_W = 16;

    // Wide all-ones pattern; users cast it down to their interval width.
    localparam logic [63:0] INTERVAL_NONE = '1;

endpackage

// File: rtl/synapse_event_stage_if.sv
// Event-in / soma-out signal bundle of the synapse stage.
interface synapse_event_stage_if
    import neuron_pkg::*;
#(
    parameter int ID_W = 4,
    parameter int T_W  = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [ID_W-1:0]  in_pre_id;
    logic [T_W-1:0]   in_time;
    logic             soma_busy;
    logic             out_valid;
    logic [W_W-1:0]   out_weight;
    logic [T_W-1:0]   out_interval;

    // master: event producer and soma side; slave: the synapse stage
    modport master (
        output in_valid, in_pre_id, in_time, soma_busy,
        input  in_ready, out_valid, out_weight, out_interval
    );

    modport slave (
        input  in_valid, in_pre_id, in_time, soma_busy,
        output in_ready, out_valid, out_weight, out_interval
    );

endinterface

// File: rtl/sync_event_fifo.sv
// Small synchronous FIFO with show-ahead head, flush and count-based flags.
module sync_event_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);

endmodule

// File: rtl/synapse_event_stage.sv
// Synapse stage: queues spike events, looks up weights, measures inter-spike
// interval and hands {weight, interval} to the soma as a one-cycle pulse.
module synapse_event_stage
    import neuron_pkg::*;
#(
    parameter int N_SYN = 16,
    parameter int ID_W  = 4,
    parameter int DEPTH = 4,
    parameter int T_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    kill,
    input  logic                    en,
    input  logic                    cfg_we,
    input  logic [ID_W-1:0]         cfg_addr,
    input  logic [W_W-1:0]          cfg_wdata,
    synapse_event_stage_if.slave    bus,
    output logic [15:0]             drop_cnt
);

    localparam int EV_W = ID_W + T_W;

    logic             fifo_push;
    logic             fifo_pop;
    logic [EV_W-1:0]  fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [ID_W-1:0]  head_id;
    logic [T_W-1:0]   head_time;

    state_t           state_reg;
    state_t           state_next;
    logic             load_ev;
    logic             drop_ev;
    logic             issue_load;
    logic             commit;

    logic [T_W-1:0]   ev_time_reg;
    logic [W_W-1:0]   ev_weight_reg;
    logic [T_W-1:0]   last_time_reg;
    logic             has_last_reg;
    logic [W_W-1:0]   out_weight_reg;
    logic [T_W-1:0]   out_interval_reg;
    logic [15:0]      drop_cnt_reg;
    logic [T_W-1:0]   interval_next;

    logic [W_W-1:0]   weight_word [N_SYN];

    // A push coinciding with kill is discarded along with the queue.
    assign fifo_push    = bus.in_valid && !fifo_full && !kill;
    assign bus.in_ready = !fifo_full;
    assign head_id      = fifo_head[EV_W-1:T_W];
    assign head_time    = fifo_head[T_W-1:0];

    sync_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (kill),
        .push    (fifo_push),
        .wr_data ({bus.in_pre_id, bus.in_time}),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // One register per synapse; the pop-side read sees the pre-write value.
    for (genvar gi = 0; gi < N_SYN; gi++) begin : g_weight
        logic [W_W-1:0] weight_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                weight_reg <= '0;
            end else if (cfg_we && (cfg_addr == ID_W'(gi))) begin
                weight_reg <= cfg_wdata;
            end
        end

        assign weight_word[gi] = weight_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        fifo_pop   = 1'b0;
        load_ev    = 1'b0;
        drop_ev    = 1'b0;
        issue_load = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (en && !fifo_empty) begin
                    fifo_pop   = 1'b1;
                    load_ev    = 1'b1;
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.soma_busy) begin
                    drop_ev    = 1'b1;
                    state_next = IDLE;
                end else begin
                    issue_load = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // kill abandons whatever is in flight without counting it as a drop
        if (kill) begin
            state_next = IDLE;
            fifo_pop   = 1'b0;
            load_ev    = 1'b0;
            drop_ev    = 1'b0;
            issue_load = 1'b0;
            commit     = 1'b0;
        end
    end

    assign interval_next = has_last_reg ? (ev_time_reg - last_time_reg)
                                        : T_W'(INTERVAL_NONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_time_reg      <= '0;
            ev_weight_reg    <= '0;
            last_time_reg    <= '0;
            has_last_reg     <= 1'b0;
            out_weight_reg   <= '0;
            out_interval_reg <= '0;
            drop_cnt_reg     <= '0;
        end else begin
            if (load_ev) begin
                ev_time_reg   <= head_time;
                ev_weight_reg <= weight_word[head_id];
            end
            if (issue_load) begin
                out_weight_reg   <= ev_weight_reg;
                out_interval_reg <= interval_next;
            end
            if (drop_ev && (drop_cnt_reg != 16'hFFFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
            if (kill) begin
                has_last_reg <= 1'b0;
            end else if (commit) begin
                last_time_reg <= ev_time_reg;
                has_last_reg  <= 1'b1;
            end
        end
    end

    assign bus.out_valid    = (state_reg == ISSUE) && !kill;
    assign bus.out_weight   = out_weight_reg;
    assign bus.out_interval = out_interval_reg;
    assign drop_cnt         = drop_cnt_reg;

endmodule

// File: tb/tb_synapse_event_stage.sv
// Directed plus randomized bench for synapse_event_stage against a
// transaction-level model of weights, intervals and drops.
module tb_synapse_event_stage;

    logic        clk;
    logic        rst;
    logic        kill;
    logic        en;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] drop_cnt;

    synapse_event_stage_if #(.ID_W(4), .T_W(16)) bus ();

    synapse_event_stage #(
        .N_SYN (16),
        .ID_W  (4),
        .DEPTH (4),
        .T_W   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .kill      (kill),
        .en        (en),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .bus       (bus),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int push_cyc = 0;
    int obs_cyc = 0;
    int dbl_cnt = 0;
    bit prev_v = 1'b0;

    // model state
    logic [15:0] mw [16];
    bit          m_has_last;
    logic [15:0] m_last;
    int          m_drops;
    logic [31:0] exp_q [$];
    logic [31:0] obs_q [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            obs_q.push_back({bus.out_weight, bus.out_interval});
            obs_cyc = cyc;
            if (prev_v) dbl_cnt++;
        end
        prev_v = (bus.out_valid === 1'b1);
    end

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void expect_deliver(input int id, input logic [15:0] t);
        logic [15:0] iv;
        iv = m_has_last ? 16'(t - m_last) : 16'hFFFF;
        exp_q.push_back({mw[id], iv});
        m_last     = t;
        m_has_last = 1'b1;
    endfunction

    function automatic void expect_drop();
        if (m_drops < 65535) m_drops++;
    endfunction

    task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
        mw[a]     = d;
    endtask

    task automatic push(input logic [3:0] id, input logic [15:0] t);
        int n;
        bus.in_pre_id = id;
        bus.in_time   = t;
        bus.in_valid  = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("push_ready", bus.in_ready, 1);
        tick();
        push_cyc     = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 300) begin
            tick();
            n++;
        end
        repeat (6) tick();
        check($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            check(tag, obs_q.pop_front(), exp_q.pop_front());
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [15:0] t;
        logic [3:0]  id;
        bit          busy;

        rst = 1'b1; kill = 1'b0; en = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        bus.in_valid = 1'b0; bus.in_pre_id = '0; bus.in_time = '0;
        bus.soma_busy = 1'b0;
        for (int i = 0; i < 16; i++) mw[i] = '0;
        m_has_last = 1'b0; m_last = '0; m_drops = 0;
        tick(); tick();
        rst = 1'b0;

        // reset state
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_weight", bus.out_weight, 0);
        check("rst_out_interval", bus.out_interval, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_drop_cnt", drop_cnt, 0);

        // basic delivery and latency
        cfg_write(4'd3, 16'h0040);
        push(4'd3, 16'd100); expect_deliver(3, 16'd100);
        drain("basic1");
        check("basic1_latency", obs_cyc - push_cyc, 2);
        push(4'd3, 16'd130); expect_deliver(3, 16'd130);
        drain("basic2");
        check("hold_weight", bus.out_weight, 16'h0040);
        check("hold_interval", bus.out_interval, 16'd30);

        // wrap-around
        push(4'd3, 16'hFFF0); expect_deliver(3, 16'hFFF0);
        push(4'd3, 16'h0010); expect_deliver(3, 16'h0010);
        drain("wrap");
        check("wrap_interval", bus.out_interval, 16'h0020);

        // full / backpressure
        cfg_write(4'd7, 16'h1234);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(4'd7, 16'(1000 + i * 10));
            expect_deliver(7, 16'(1000 + i * 10));
        end
        check("full_in_ready", bus.in_ready, 0);
        bus.in_pre_id = 4'd7; bus.in_time = 16'd1100; bus.in_valid = 1'b1;
        repeat (3) tick();
        check("full_held_ready", bus.in_ready, 0);
        check("full_no_output", obs_q.size(), 0);
        en = 1'b1;
        push(4'd7, 16'd1100); expect_deliver(7, 16'd1100);
        drain("full");

        // refractory drop
        bus.soma_busy = 1'b1;
        push(4'd3, 16'd200); expect_drop();
        repeat (6) tick();
        bus.soma_busy = 1'b0;
        check("drop_cnt1", drop_cnt, 16'(m_drops));
        push(4'd3, 16'd250); expect_deliver(3, 16'd250);
        drain("drop");

        // kill during LOOKUP, with a push offered in the kill cycle
        en = 1'b0;
        push(4'd3, 16'd300); push(4'd3, 16'd310); push(4'd3, 16'd320);
        en = 1'b1;
        tick();
        kill = 1'b1;
        bus.in_pre_id = 4'd3; bus.in_time = 16'd330; bus.in_valid = 1'b1;
        tick();
        kill = 1'b0; bus.in_valid = 1'b0;
        m_has_last = 1'b0;
        check("kill_in_ready", bus.in_ready, 1);
        repeat (6) tick();
        check("kill_no_output", obs_q.size(), 0);
        check("kill_drop_kept", drop_cnt, 16'(m_drops));
        push(4'd3, 16'd400); expect_deliver(3, 16'd400);
        drain("kill");

        // reset mid-flight
        en = 1'b0;
        push(4'd3, 16'd500); push(4'd7, 16'd510); push(4'd3, 16'd520);
        en = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mw[i] = '0;
        m_has_last = 1'b0; m_drops = 0;
        check("rst2_drop_cnt", drop_cnt, 0);
        check("rst2_out_weight", bus.out_weight, 0);
        check("rst2_in_ready", bus.in_ready, 1);
        repeat (6) tick();
        check("rst2_no_output", obs_q.size(), 0);
        push(4'd3, 16'd600); expect_deliver(3, 16'd600);
        drain("rst2");

        // config write colliding with the pop of the same address
        cfg_write(4'd5, 16'h0022);
        en = 1'b0;
        push(4'd5, 16'd700); expect_deliver(5, 16'd700);
        en = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd5; cfg_wdata = 16'h0011;
        tick();
        cfg_we = 1'b0; mw[5] = 16'h0011;
        push(4'd5, 16'd720); expect_deliver(5, 16'd720);
        drain("collide");

        // randomized traffic with en toggling
        for (int i = 0; i < 16; i++) cfg_write(4'(i), 16'($urandom));
        t = 16'($urandom);
        for (int i = 0; i < 40; i++) begin
            en = ($urandom_range(0, 3) != 0);
            if (bus.in_ready !== 1'b1) en = 1'b1;
            id = 4'($urandom_range(0, 15));
            t  = t + 16'($urandom_range(0, 4000));
            push(id, t); expect_deliver(id, t);
        end
        en = 1'b1;
        drain("rand");

        // randomized refractory drops
        for (int i = 0; i < 16; i++) begin
            busy = 1'($urandom_range(0, 1));
            id   = 4'($urandom_range(0, 15));
            t    = t + 16'($urandom_range(1, 3000));
            bus.soma_busy = busy;
            push(id, t);
            if (busy) expect_drop(); else expect_deliver(id, t);
            repeat (6) tick();
            bus.soma_busy = 1'b0;
        end
        drain("rand_drop");
        check("rand_drop_cnt", drop_cnt, 16'(m_drops));

        check("single_pulse", dbl_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
